// File: rtl/n64_responder.sv
// N64 controller-side protocol engine: decodes host command bytes on the single-wire
// line and answers status/poll commands open-drain from a snapshot of the button bus.
module n64_responder #(
    parameter int clockfreq     = 27000000,
    parameter int turnaround_us = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    inout  wire         N64_DQ,
    input  logic [29:0] Buttons,
    output logic [7:0]  Cmd,
    output logic        CmdValid,
    output logic        Polled,
    output logic        Busy
);
    localparam int US = clockfreq / 1000000;
    localparam logic [15:0] C_1US  = 16'(US);
    localparam logic [15:0] C_2US  = 16'(2 * US);
    localparam logic [15:0] C_3US  = 16'(3 * US);
    localparam logic [15:0] C_4US  = 16'(4 * US);
    localparam logic [15:0] C_5US  = 16'(5 * US);
    localparam logic [15:0] C_TURN = 16'(turnaround_us * US);

    typedef enum logic [2:0] {S_IDLE, S_RXBIT, S_RXSTOP, S_TURN, S_TXBIT, S_TXSTOP} state_t;

    state_t      r_state;
    logic        r_dq_m, r_dq_s, r_dq_d;
    logic [15:0] r_cnt, r_hi;
    logic [2:0]  r_bitn;
    logic        r_sampled, r_stop_seen, r_is_poll;
    logic [7:0]  r_rxsr;
    logic [31:0] r_txsr;
    logic [5:0]  r_txi, r_txlast;
    logic        r_drive;
    logic [7:0]  r_cmd;
    logic        r_cmdv, r_polled, r_busy;

    logic w_fall, w_rise, w_timeout;
    assign w_fall    = r_dq_d & ~r_dq_s;
    assign w_rise    = ~r_dq_d & r_dq_s;
    assign w_timeout = (r_hi >= (C_5US - 16'd1));

    assign N64_DQ   = r_drive ? 1'b0 : 1'bz;
    assign Cmd      = r_cmd;
    assign CmdValid = r_cmdv;
    assign Polled   = r_polled;
    assign Busy     = r_busy;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_dq_m      <= 1'b1;
            r_dq_s      <= 1'b1;
            r_dq_d      <= 1'b1;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_bitn      <= '0;
            r_sampled   <= 1'b0;
            r_stop_seen <= 1'b0;
            r_is_poll   <= 1'b0;
            r_rxsr      <= '0;
            r_txsr      <= '0;
            r_txi       <= '0;
            r_txlast    <= '0;
            r_drive     <= 1'b0;
            r_cmd       <= 8'h00;
            r_cmdv      <= 1'b0;
            r_polled    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_dq_m   <= N64_DQ;
            r_dq_s   <= r_dq_m;
            r_dq_d   <= r_dq_s;
            r_cmdv   <= 1'b0;
            r_polled <= 1'b0;
            // Idle-high run length, used for the receive-side abort timeout
            if (!r_dq_s)
                r_hi <= '0;
            else if (r_hi != 16'hFFFF)
                r_hi <= r_hi + 16'd1;

            case (r_state)
                S_IDLE: begin
                    r_drive <= 1'b0;
                    if (w_fall) begin
                        r_busy    <= 1'b1;
                        r_bitn    <= '0;
                        r_cnt     <= '0;
                        r_sampled <= 1'b0;
                        r_state   <= S_RXBIT;
                    end
                end
                S_RXBIT: begin
                    if (w_fall) begin
                        r_cnt     <= '0;
                        r_sampled <= 1'b0;
                    end else if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if (!r_sampled && r_cnt == C_2US - 16'd1) begin
                            r_sampled <= 1'b1;
                            r_rxsr    <= {r_rxsr[6:0], r_dq_s};
                            r_bitn    <= r_bitn + 3'd1;
                            if (r_bitn == 3'd7) begin
                                r_stop_seen <= 1'b0;
                                r_state     <= S_RXSTOP;
                            end
                        end
                    end
                end
                S_RXSTOP: begin
                    if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_fall) begin
                        r_stop_seen <= 1'b1;
                    end else if (w_rise && r_stop_seen) begin
                        r_cmd  <= r_rxsr;
                        r_cmdv <= 1'b1;
                        r_cnt  <= '0;
                        case (r_rxsr)
                            8'h00, 8'hFF: begin
                                r_txsr    <= {24'h050002, 8'h00};
                                r_txlast  <= 6'd23;
                                r_is_poll <= 1'b0;
                                r_state   <= S_TURN;
                            end
                            8'h01: begin
                                r_txsr    <= {Buttons[29:22], 2'b00, Buttons[21:16], Buttons[15:0]};
                                r_txlast  <= 6'd31;
                                r_is_poll <= 1'b1;
                                r_state   <= S_TURN;
                            end
                            default: begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_TURN: begin
                    if (r_cnt == C_TURN - 16'd1) begin
                        r_cnt   <= '0;
                        r_txi   <= '0;
                        r_drive <= 1'b1;
                        r_state <= S_TXBIT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_TXBIT: begin
                    // Each bit starts low; the low length encodes the bit value
                    if (r_cnt == C_4US - 16'd1) begin
                        r_cnt   <= '0;
                        r_drive <= 1'b1;
                        if (r_txi == r_txlast) begin
                            r_state <= S_TXSTOP;
                        end else begin
                            r_txi  <= r_txi + 6'd1;
                            r_txsr <= {r_txsr[30:0], 1'b0};
                        end
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                        r_drive <= ((r_cnt + 16'd1) < (r_txsr[31] ? C_1US : C_3US));
                    end
                end
                S_TXSTOP: begin
                    if (r_cnt == C_4US - 16'd1) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                        r_drive <= ((r_cnt + 16'd1) < C_2US);
                        if (r_cnt == C_2US - 16'd1)
                            r_polled <= r_is_poll;
                    end
                end
                default: begin
                    r_drive <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
